// File: rtl/timer_seq_pkg.sv
// ============================================================================
//  Module      : timer_seq_pkg
//  Description : Shared types, register map and helpers for timer_sequencer.
//                Snapshot states exist only with TIMER_SEQ_SNAPSHOT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_P0   = 4'd1,
        ST_WR_P1   = 4'd2,
        ST_WR_P2   = 4'd3,
        ST_WR_P3   = 4'd4,
        ST_WR_CTRL = 4'd5,
        ST_RUN     = 4'd6,
        ST_ACK     = 4'd7,
        ST_STOP    = 4'd8
`ifdef TIMER_SEQ_SNAPSHOT_EN
        ,
        ST_SNAP_W  = 4'd9,
        ST_SNAP_RD = 4'd10
`endif
    } seq_state_t;

    localparam logic [3:0] ADDR_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_CONTROL = 4'd1;
    localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
    localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
    localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
    localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
    localparam logic [3:0] ADDR_SNAP0   = 4'd6;
    localparam logic [3:0] ADDR_SNAP1   = 4'd7;
    localparam logic [3:0] ADDR_SNAP2   = 4'd8;
    localparam logic [3:0] ADDR_SNAP3   = 4'd9;

    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [3:0]  addr;
        logic [15:0] data;
    } avm_cmd_t;

    function automatic avm_cmd_t bus_write(input logic [3:0] addr, input logic [15:0] data);
        avm_cmd_t c;
        c.cs      = 1'b1;
        c.write_n = 1'b0;
        c.addr    = addr;
        c.data    = data;
        return c;
    endfunction

    // Idle bus keeps the address so read sequences can present it with cs low.
    function automatic avm_cmd_t bus_idle(input logic [3:0] addr);
        avm_cmd_t c;
        c.cs      = 1'b0;
        c.write_n = 1'b1;
        c.addr    = addr;
        c.data    = 16'h0000;
        return c;
    endfunction

    function automatic logic [15:0] ctrl_word(input logic start, input logic cont,
                                              input logic ito, input logic stop);
        logic [15:0] w;
        w        = 16'h0000;
        w[START] = start;
        w[CONT]  = cont;
        w[ITO]   = ito;
        w[STOP]  = stop;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_seq_channel.sv
// ============================================================================
//  Module      : timer_seq_channel
//  Description : Divides serviced timer ticks into a periodic event pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_seq_channel #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              en,
    input  logic [TICK_W-1:0] div,
    input  logic              tick,
    output logic              evt
);

    logic [TICK_W-1:0] r_cnt;

    // A zero divisor never fires; >= lets a counter left above a lowered divisor recover.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            evt   <= 1'b0;
        end else begin
            evt <= 1'b0;
            if (clear || !en) begin
                r_cnt <= '0;
            end else if (tick) begin
                if ((div != '0) && (r_cnt >= div - 1'b1)) begin
                    r_cnt <= '0;
                    evt   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_sequencer.sv
// ============================================================================
//  Module      : timer_sequencer
//  Description : Avalon-MM master that programs and services the interval
//                timer, counts ticks and divides them into event strobes.
//                TIMER_SEQ_SNAPSHOT_EN adds counter snapshot readback
//                (snap_req/snap_valid/snap_value and avm_readdata ports).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TICK_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [63:0]              cfg_period,
    input  logic                     cfg_continuous,
    input  logic                     stop_req,
    output logic                     busy,
    output logic                     done,
    output logic                     tick,
    output logic [TICK_W-1:0]        tick_count,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*TICK_W-1:0] ch_div,
    output logic [NUM_CH-1:0]        ch_evt,
    input  logic                     timer_irq,
`ifdef TIMER_SEQ_SNAPSHOT_EN
    input  logic [15:0]              avm_readdata,
    input  logic                     snap_req,
    output logic                     snap_valid,
    output logic [63:0]              snap_value,
`endif
    output logic [3:0]               avm_address,
    output logic                     avm_chipselect,
    output logic                     avm_write_n,
    output logic [15:0]              avm_writedata
);

    seq_state_t  r_state;
    avm_cmd_t    r_bus;
    logic [47:0] r_period_hi;
    logic        r_cont;
    logic        r_stop_pend;

    logic w_accept;
    logic w_fire;
    logic w_in_wr;
    logic w_stop_seen;

    assign w_accept    = cfg_valid && cfg_ready;
    assign w_fire      = (r_state == ST_RUN) && timer_irq;
    assign w_in_wr     = (r_state == ST_WR_P0) || (r_state == ST_WR_P1) ||
                         (r_state == ST_WR_P2) || (r_state == ST_WR_P3) ||
                         (r_state == ST_WR_CTRL);
    // Requests are only honoured while a run is being set up or is running.
    assign w_stop_seen = r_stop_pend || (stop_req && (w_in_wr || (r_state == ST_RUN)));

`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic       r_snap_pend;
    logic [2:0] r_snap_idx;
    logic       w_snap_seen;

    assign w_snap_seen = r_snap_pend || (snap_req && (w_in_wr || (r_state == ST_RUN)));
`endif

    assign avm_address    = r_bus.addr;
    assign avm_chipselect = r_bus.cs;
    assign avm_write_n    = r_bus.write_n;
    assign avm_writedata  = r_bus.data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bus       <= bus_idle(ADDR_STATUS);
            r_period_hi <= '0;
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
            cfg_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            tick        <= 1'b0;
            tick_count  <= '0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            r_snap_pend <= 1'b0;
            r_snap_idx  <= 3'd0;
            snap_valid  <= 1'b0;
            snap_value  <= 64'h0;
`endif
        end else begin
            done        <= 1'b0;
            tick        <= 1'b0;
            r_stop_pend <= w_stop_seen;
            r_bus       <= bus_idle(r_bus.addr);
`ifdef TIMER_SEQ_SNAPSHOT_EN
            r_snap_pend <= w_snap_seen;
            snap_valid  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_stop_pend <= 1'b0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
                    r_snap_pend <= 1'b0;
`endif
                    if (w_accept) begin
                        r_period_hi <= cfg_period[63:16];
                        r_cont      <= cfg_continuous;
                        tick_count  <= '0;
                        cfg_ready   <= 1'b0;
                        busy        <= 1'b1;
                        r_bus       <= bus_write(ADDR_PERIOD0, cfg_period[15:0]);
                        r_state     <= ST_WR_P0;
                    end
                end
                ST_WR_P0: begin
                    r_bus   <= bus_write(ADDR_PERIOD1, r_period_hi[15:0]);
                    r_state <= ST_WR_P1;
                end
                ST_WR_P1: begin
                    r_bus   <= bus_write(ADDR_PERIOD2, r_period_hi[31:16]);
                    r_state <= ST_WR_P2;
                end
                ST_WR_P2: begin
                    r_bus   <= bus_write(ADDR_PERIOD3, r_period_hi[47:32]);
                    r_state <= ST_WR_P3;
                end
                ST_WR_P3: begin
                    r_bus   <= bus_write(ADDR_CONTROL, ctrl_word(1'b1, r_cont, 1'b1, 1'b0));
                    r_state <= ST_WR_CTRL;
                end
                ST_WR_CTRL: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_fire) begin
                        r_bus      <= bus_write(ADDR_STATUS, 16'h0000);
                        tick       <= 1'b1;
                        tick_count <= tick_count + 1'b1;
                        r_state    <= ST_ACK;
                    end else if (w_stop_seen) begin
                        r_bus       <= bus_write(ADDR_CONTROL, ctrl_word(1'b0, 1'b0, 1'b0, 1'b1));
                        r_stop_pend <= 1'b0;
                        r_state     <= ST_STOP;
                    end
`ifdef TIMER_SEQ_SNAPSHOT_EN
                    else if (w_snap_seen) begin
                        r_bus       <= bus_write(ADDR_SNAP0, 16'h0000);
                        r_snap_pend <= 1'b0;
                        r_state     <= ST_SNAP_W;
                    end
`endif
                end
                ST_ACK: begin
                    if (r_cont) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_stop_pend <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        cfg_ready   <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_STOP: begin
                    r_stop_pend <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    cfg_ready   <= 1'b1;
                    r_state     <= ST_IDLE;
                end
`ifdef TIMER_SEQ_SNAPSHOT_EN
                ST_SNAP_W: begin
                    r_bus      <= bus_idle(ADDR_SNAP0);
                    r_snap_idx <= 3'd0;
                    r_state    <= ST_SNAP_RD;
                end
                // Slave read data lags the address by one cycle: capture idx 1..4.
                ST_SNAP_RD: begin
                    case (r_snap_idx)
                        3'd1:    snap_value[15:0]  <= avm_readdata;
                        3'd2:    snap_value[31:16] <= avm_readdata;
                        3'd3:    snap_value[47:32] <= avm_readdata;
                        3'd4:    snap_value[63:48] <= avm_readdata;
                        default: ;
                    endcase
                    if (r_snap_idx == 3'd4) begin
                        snap_valid <= 1'b1;
                        r_state    <= ST_RUN;
                    end else begin
                        r_snap_idx <= r_snap_idx + 3'd1;
                        if (r_snap_idx != 3'd3) begin
                            r_bus <= bus_idle(r_bus.addr + 4'd1);
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        timer_seq_channel #(
            .TICK_W (TICK_W)
        ) u_channel (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (w_accept),
            .en      (ch_en[gi]),
            .div     (ch_div[gi*TICK_W +: TICK_W]),
            .tick    (w_fire),
            .evt     (ch_evt[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_sequencer.sv
// ============================================================================
//  Module      : tb_timer_sequencer
//  Description : Self-checking bench for timer_sequencer with an interval
//                timer slave model and session-level expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_sequencer;

    localparam int NUM_CH = 4;
    localparam int TICK_W = 16;
    localparam int BUDGET = 3000;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [63:0]              cfg_period;
    logic                     cfg_continuous;
    logic                     stop_req;
    logic                     busy;
    logic                     done;
    logic                     tick;
    logic [TICK_W-1:0]        tick_count;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*TICK_W-1:0] ch_div;
    logic [NUM_CH-1:0]        ch_evt;
    logic                     timer_irq;
    logic [3:0]               avm_address;
    logic                     avm_chipselect;
    logic                     avm_write_n;
    logic [15:0]              avm_writedata;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic [15:0]              avm_readdata;
    logic                     snap_req;
    logic                     snap_valid;
    logic [63:0]              snap_value;
`endif

    always #5 clk = ~clk;

    timer_sequencer #(
        .NUM_CH (NUM_CH),
        .TICK_W (TICK_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .stop_req       (stop_req),
        .busy           (busy),
        .done           (done),
        .tick           (tick),
        .tick_count     (tick_count),
        .ch_en          (ch_en),
        .ch_div         (ch_div),
        .ch_evt         (ch_evt),
        .timer_irq      (timer_irq),
`ifdef TIMER_SEQ_SNAPSHOT_EN
        .avm_readdata   (avm_readdata),
        .snap_req       (snap_req),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
`endif
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata)
    );

    // Interval timer slave: counts period..0, sets TO at zero, reloads if continuous.
    logic [63:0] tm_period, tm_counter, tm_snap;
    logic        tm_run, tm_cont, tm_ito, tm_to;
    int          tm_timeouts;
    wire         w_wr = avm_chipselect & ~avm_write_n;

    assign timer_irq = tm_to & tm_ito;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_period <= '0; tm_counter <= '0; tm_snap <= '0;
            tm_run <= 1'b0; tm_cont <= 1'b0; tm_ito <= 1'b0; tm_to <= 1'b0;
            tm_timeouts <= 0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            avm_readdata <= '0;
`endif
        end else begin
            if (tm_run) begin
                if (tm_counter == 64'd0) begin
                    tm_to       <= 1'b1;
                    tm_timeouts <= tm_timeouts + 1;
                    tm_counter  <= tm_period;
                    if (!tm_cont) tm_run <= 1'b0;
                end else begin
                    tm_counter <= tm_counter - 64'd1;
                end
            end
            if (w_wr) begin
                case (avm_address)
                    4'd0: tm_to <= 1'b0;
                    4'd1: begin
                        tm_cont <= avm_writedata[1];
                        tm_ito  <= avm_writedata[0];
                        if (avm_writedata[3]) tm_run <= 1'b0;
                        else if (avm_writedata[2]) begin
                            tm_run     <= 1'b1;
                            tm_counter <= tm_period;
                        end
                    end
                    4'd2: tm_period[15:0]  <= avm_writedata;
                    4'd3: tm_period[31:16] <= avm_writedata;
                    4'd4: tm_period[47:32] <= avm_writedata;
                    4'd5: tm_period[63:48] <= avm_writedata;
                    4'd6: tm_snap <= tm_counter;
                    default: ;
                endcase
            end
`ifdef TIMER_SEQ_SNAPSHOT_EN
            case (avm_address)
                4'd6: avm_readdata <= tm_snap[15:0];
                4'd7: avm_readdata <= tm_snap[31:16];
                4'd8: avm_readdata <= tm_snap[47:32];
                4'd9: avm_readdata <= tm_snap[63:48];
                default: avm_readdata <= 16'h0;
            endcase
`endif
        end
    end

    // Bus and pulse monitor
    logic [19:0] wlog[$];
    int          n_tick = 0;
    int          n_done = 0;
    int          n_evt[NUM_CH];

    initial for (int i = 0; i < NUM_CH; i++) n_evt[i] = 0;

    always @(negedge clk) begin
        if (avm_chipselect && !avm_write_n) wlog.push_back({avm_address, avm_writedata});
        if (tick) n_tick++;
        if (done) n_done++;
        for (int i = 0; i < NUM_CH; i++) if (ch_evt[i]) n_evt[i]++;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_stop();
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
    endtask

    // mode 0: one-shot, 1: stop after nt ticks, 2: stop coincident with irq, 3: stop during setup
    task automatic run_session(input string tag, input logic [63:0] period, input logic cont,
                               input int mode, input int nt_req, input logic [NUM_CH-1:0] en,
                               input logic [NUM_CH*TICK_W-1:0] div, input bit cyc_checks);
        int          b_to, b_tick, b_done, b_w, nt;
        int          b_evt[NUM_CH];
        logic [19:0] exp_w[$];
        logic [15:0] d;
        bit          ok;

        nt     = (mode == 0) ? 1 : ((mode == 3) ? 0 : nt_req);
        b_to   = tm_timeouts;
        b_tick = n_tick;
        b_done = n_done;
        b_w    = wlog.size();
        for (int i = 0; i < NUM_CH; i++) b_evt[i] = n_evt[i];
        ch_en  = en;
        ch_div = div;

        @(negedge clk);
        check({tag, "_ready"}, {63'd0, cfg_ready}, 64'd1);
        cfg_valid      = 1'b1;
        cfg_period     = period;
        cfg_continuous = cont;
        @(negedge clk);
        cfg_valid      = 1'b0;
        cfg_period     = {$urandom, $urandom};
        cfg_continuous = ~cont;

        if (cyc_checks) begin
            for (int k = 0; k < 5; k++) begin
                d = (k < 4) ? period[16*k +: 16] : (cont ? 16'h0007 : 16'h0005);
                check($sformatf("%s_cyc%0d", tag, k + 1),
                      {42'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
                      {42'd0, 1'b1, 1'b0, (k < 4) ? 4'(k + 2) : 4'd1, d});
                @(negedge clk);
            end
            check({tag, "_cyc6_idle"}, {62'd0, avm_chipselect, busy}, 64'd1);
        end

        if (mode == 3) pulse_stop();

        if (mode == 1 || mode == 2) begin
            ok = 1'b0;
            for (int k = 0; k < BUDGET; k++) begin
                if ((tm_timeouts - b_to == nt) && (mode == 1 ? !tm_to : timer_irq)) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check({tag, "_wait_ticks"}, {63'd0, ok}, 64'd1);
            pulse_stop();
        end

        ok = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            if (n_done != b_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_wait_done"}, {63'd0, ok}, 64'd1);
        repeat (3) @(negedge clk);

        check({tag, "_done_pulses"}, 64'(n_done - b_done), 64'd1);
        check({tag, "_tick_pulses"}, 64'(n_tick - b_tick), 64'(nt));
        check({tag, "_tick_count"}, 64'(tick_count), 64'(nt));
        check({tag, "_timeouts"}, 64'(tm_timeouts - b_to), 64'(nt));
        check({tag, "_idle"}, {61'd0, busy, cfg_ready, tm_run}, {61'd0, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < NUM_CH; i++) begin
            d = div[i*TICK_W +: TICK_W];
            check($sformatf("%s_evt%0d", tag, i), 64'(n_evt[i] - b_evt[i]),
                  (en[i] && d != 0) ? 64'(nt / int'(d)) : 64'd0);
        end

        for (int k = 0; k < 4; k++) exp_w.push_back({4'(k + 2), period[16*k +: 16]});
        exp_w.push_back({4'd1, cont ? 16'h0007 : 16'h0005});
        for (int k = 0; k < nt; k++) exp_w.push_back(20'h00000);
        if (mode != 0) exp_w.push_back({4'd1, 16'h0008});
        check({tag, "_nwrites"}, 64'(wlog.size() - b_w), 64'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && (b_w + k) < wlog.size(); k++)
            check($sformatf("%s_wr%0d", tag, k), 64'(wlog[b_w + k]), 64'(exp_w[k]));
    endtask

    initial begin
        logic [NUM_CH*TICK_W-1:0] div;
        logic [63:0]              per;
        int                       mode;
        bit                       ok;

        reset_n = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_continuous = 1'b0;
        stop_req = 1'b0; ch_en = '0; ch_div = '0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
        snap_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, cfg_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done_tick", {62'd0, done, tick}, 64'd0);
        check("rst_tick_count", 64'(tick_count), 64'd0);
        check("rst_ch_evt", 64'(ch_evt), 64'd0);
        check("rst_bus", {42'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
              {42'd0, 1'b0, 1'b1, 4'd0, 16'h0000});
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_session("cont9", 64'd9, 1'b1, 1, 6, 4'hF, {16'd3, 16'd2, 16'd1, 16'd0}, 1'b1);
        run_session("coinc", 64'd7, 1'b1, 2, 3, 4'b1010, {16'd2, 16'd2, 16'd2, 16'd2}, 1'b0);
        pulse_stop();
        run_session("oneshot3", 64'd3, 1'b0, 0, 1, 4'hF, {16'd1, 16'd1, 16'd0, 16'd1}, 1'b0);
        run_session("stop_wr", 64'h0001_0002_0003_000A, 1'b1, 3, 0, 4'hF,
                    {16'd1, 16'd1, 16'd1, 16'd1}, 1'b1);

        for (int r = 0; r < 8; r++) begin
            mode = int'($urandom_range(0, 3));
            per  = 64'($urandom_range(6, 20));
            for (int i = 0; i < NUM_CH; i++) div[i*TICK_W +: TICK_W] = TICK_W'($urandom_range(0, 4));
            run_session($sformatf("rnd%0d", r), per,
                        (mode == 0) ? 1'b0 : ((mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1),
                        mode, int'($urandom_range(1, 5)), NUM_CH'($urandom), div, 1'b0);
        end

        // Reset in the middle of setup must return straight to idle.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_period = 64'd50; cfg_continuous = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("midrst", {60'd0, busy, cfg_ready, avm_chipselect, avm_write_n},
                 {60'd0, 1'b0, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {61'd0, busy, cfg_ready, tick}, {61'd0, 1'b0, 1'b1, 1'b0});

`ifdef TIMER_SEQ_SNAPSHOT_EN
        @(negedge clk);
        cfg_valid = 1'b1; cfg_period = 64'd200; cfg_continuous = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (25) @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (snap_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("snap_valid", {63'd0, ok}, 64'd1);
        check("snap_value", snap_value, tm_snap);
        pulse_stop();
        repeat (5) @(negedge clk);
        check("snap_stopped", {62'd0, busy, tm_run}, 64'd0);
`endif

        ok = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
